// File: rtl/core_hs_pkg.sv
// Shared types and helpers for the handshaked RV32I multi-cycle core.
// Holds the FSM encoding, opcode constants and the ALU/branch compare functions.
package core_hs_pkg;

    localparam int CORE_STATE_WIDTH = 2;

    typedef enum logic [CORE_STATE_WIDTH-1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // alt selects sub/sra; the caller decides when ir[30] is meaningful.
    function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic alt);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3);
        logic t;
        case (f3)
            3'd0:    t = (a == b);
            3'd1:    t = (a != b);
            3'd4:    t = ($signed(a) < $signed(b));
            3'd5:    t = !($signed(a) < $signed(b));
            3'd6:    t = (a < b);
            3'd7:    t = !(a < b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/core_hs_bus_timer.sv
// Wait-cycle counter shared by the fetch and data phases.
// expired is raised on the last permitted wait cycle; TIMEOUT=0 never expires.
module core_hs_bus_timer #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign expired = (TIMEOUT > 0) && en && (count == LAST);

endmodule

// File: rtl/core_hs.sv
// RV32I multi-cycle core with valid/ack handshakes on instruction and data ports.
// FETCH -> EXEC -> (MEM) -> FETCH; a stalled request past TIMEOUT parks the core in HALT.
module core_hs
    import core_hs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 30,
    parameter int          CNT_W    = 32,
    parameter int          TIMEOUT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_instr_req,
    output logic [ADDR_W-1:0] o_instr_addr,
    input  logic              i_instr_ack,
    input  logic [31:0]       i_instr_data,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic [3:0]        o_mem_mask,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_data,
    output logic [CNT_W-1:0]  o_retired,
    output logic              o_halted
);
    state_t state, state_next;
    logic [31:0] pc, ir, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_we;
    logic [CNT_W-1:0] retired;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign f3       = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'd0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    logic        wb_en, is_mem;
    logic [31:0] wb_data, pc_next;

    always_comb begin
        wb_en   = 1'b0;
        wb_data = 32'd0;
        pc_next = pc_plus4;
        is_mem  = 1'b0;
        case (opcode)
            OP_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = (pc + imm_j) & ~32'd3; end
            OP_JALR:   begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'd3; end
            OP_BRANCH: if (br_taken(rs1_val, rs2_val, f3)) pc_next = (pc + imm_b) & ~32'd3;
            OP_IMM:    begin wb_en = 1'b1; wb_data = alu_op(rs1_val, imm_i, f3, ir[30] && (f3 == 3'd5)); end
            OP_REG:    begin wb_en = 1'b1; wb_data = alu_op(rs1_val, rs2_val, f3, ir[30]); end
            OP_LOAD, OP_STORE: is_mem = 1'b1;
            default: ;
        endcase
    end

    // Load/store unit: lane steering on the way out, lane extraction and extension on the way in.
    logic [31:0] ea, st_data, ld_shift, ld_data;
    logic [3:0]  st_mask;

    always_comb begin
        ea       = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
        st_data  = rs2_val;
        st_mask  = 4'hF;
        case (f3[1:0])
            2'd0:    begin st_data = {4{rs2_val[7:0]}};  st_mask = 4'b0001 << ea[1:0]; end
            2'd1:    begin st_data = {2{rs2_val[15:0]}}; st_mask = 4'b0011 << ea[1:0]; end
            default: ;
        endcase
        ld_shift = i_mem_data >> {mem_addr[1:0], 3'b000};
        case (f3)
            3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_data = {24'd0, ld_shift[7:0]};
            3'd5:    ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    logic        rf_we;
    logic [31:0] rf_wdata;

    assign rf_we    = (rd != 5'd0) &&
                      (((state == ST_EXEC) && !is_mem && wb_en) ||
                       ((state == ST_MEM) && i_mem_ack && !mem_we));
    assign rf_wdata = (state == ST_MEM) ? ld_data : wb_data;

    always_ff @(posedge clk) begin
        if (rf_we)
            regs[rd] <= rf_wdata;
    end

    logic timer_expired;

    core_hs_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_next != state),
        .en      ((state == ST_FETCH) || (state == ST_MEM)),
        .expired (timer_expired)
    );

    // An ack on the expiry cycle still completes the transfer.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: if (i_instr_ack) state_next = ST_EXEC;
                      else if (timer_expired) state_next = ST_HALT;
            ST_EXEC:  state_next = is_mem ? ST_MEM : ST_FETCH;
            ST_MEM:   if (i_mem_ack) state_next = ST_FETCH;
                      else if (timer_expired) state_next = ST_HALT;
            default:  state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_mask  <= 4'd0;
            mem_we    <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_FETCH: if (i_instr_ack) ir <= i_instr_data;
                ST_EXEC: begin
                    if (is_mem) begin
                        mem_addr  <= ea;
                        mem_wdata <= st_data;
                        mem_mask  <= st_mask;
                        mem_we    <= (opcode == OP_STORE);
                    end else begin
                        pc      <= pc_next;
                        retired <= retired + 1'b1;
                    end
                end
                ST_MEM: if (i_mem_ack) begin
                    pc      <= pc_plus4;
                    retired <= retired + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_instr_req  = (state == ST_FETCH) && !rst;
    assign o_instr_addr = pc[ADDR_W+1:2];
    assign o_mem_req    = (state == ST_MEM) && !rst;
    assign o_mem_we     = o_mem_req && mem_we;
    assign o_mem_addr   = mem_addr[ADDR_W+1:2];
    assign o_mem_data   = mem_wdata;
    assign o_mem_mask   = mem_mask;
    assign o_retired    = retired;
    assign o_halted     = (state == ST_HALT);

endmodule

// File: tb/tb_core_hs.sv
// Directed-vector bench for core_hs: reset, wait states, load/store, branch, timeout and reset mid-request.
module tb_core_hs;

    logic        clk;
    logic        rst;
    logic        instr_req, instr_ack, mem_req, mem_we, mem_ack, halted;
    logic [29:0] instr_addr, mem_addr;
    logic [31:0] instr_data, mem_wdata, mem_rdata, retired;
    logic [3:0]  mem_mask;

    int checks = 0;
    int errors = 0;

    core_hs #(.RESET_PC(32'h100), .ADDR_W(30), .CNT_W(32), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .o_instr_req  (instr_req),
        .o_instr_addr (instr_addr),
        .i_instr_ack  (instr_ack),
        .i_instr_data (instr_data),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_wdata),
        .o_mem_mask   (mem_mask),
        .i_mem_ack    (mem_ack),
        .i_mem_data   (mem_rdata),
        .o_retired    (retired),
        .o_halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_fetch(input logic [31:0] instr, input int waits);
        instr_ack = 1'b0;
        repeat (waits) step();
        instr_ack  = 1'b1;
        instr_data = instr;
        step();
        instr_ack  = 1'b0;
        instr_data = 32'd0;
    endtask

    task automatic serve_mem(input logic [31:0] data, input int waits);
        mem_ack = 1'b0;
        repeat (waits) step();
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ack = 1'b0; mem_ack = 1'b0; instr_data = 32'd0; mem_rdata = 32'd0;
        step(); step();
        checks++; if (instr_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_instr_req: got %b expected 0", instr_req); end
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mem_req_we: got %b expected 00", {mem_req, mem_we}); end
        checks++; if (retired !== 32'd0) begin errors++; $display("[TB] FAIL rst_retired: got %0d expected 0", retired); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL rst_halted: got %b expected 0", halted); end
        rst = 1'b0;
        #1;
        checks++; if (instr_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", instr_req); end
        checks++; if (instr_addr !== 30'h40) begin errors++; $display("[TB] FAIL first_addr: got %h expected 40", instr_addr); end
    endtask

    // addi x1,x0,5 acked on the 4th request cycle, which is also the timeout boundary.
    task automatic test_wait_states();
        instr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({instr_req, instr_addr} !== {1'b1, 30'h40}) begin errors++; $display("[TB] FAIL ws_req_held[%0d]: got %b/%h expected 1/40", i, instr_req, instr_addr); end
            step();
        end
        instr_ack = 1'b1; instr_data = 32'h0050_0093;
        step();
        instr_ack = 1'b0;
        checks++; if ({instr_req, retired} !== {1'b0, 32'd0}) begin errors++; $display("[TB] FAIL ws_exec: got req=%b ret=%0d expected req=0 ret=0", instr_req, retired); end
        step();
        checks++; if (retired !== 32'd1) begin errors++; $display("[TB] FAIL ws_retired: got %0d expected 1", retired); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL ws_ack_beats_timeout: got halted=%b expected 0", halted); end
        checks++; if ({instr_req, instr_addr} !== {1'b1, 30'h41}) begin errors++; $display("[TB] FAIL ws_next_fetch: got %b/%h expected 1/41", instr_req, instr_addr); end
    endtask

    task automatic test_load_store();
        serve_fetch(32'h0010_2423, 0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sw_exec_no_req: got %b expected 0", mem_req); end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++; if ({mem_req, mem_we, mem_addr, mem_mask, mem_wdata} !== {1'b1, 1'b1, 30'h2, 4'hF, 32'd5})
                begin errors++; $display("[TB] FAIL sw_x1_held[%0d]: got %b %b %h %h %h expected 1 1 2 f 5", i, mem_req, mem_we, mem_addr, mem_mask, mem_wdata); end
            if (i == 1) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        checks++; if ({retired, instr_addr} !== {32'd2, 30'h42}) begin errors++; $display("[TB] FAIL sw_done: got ret=%0d addr=%h expected 2/42", retired, instr_addr); end

        serve_fetch(32'h0080_2103, 0);
        step();
        checks++; if ({mem_req, mem_we, mem_addr, mem_mask} !== {1'b1, 1'b0, 30'h2, 4'hF}) begin errors++; $display("[TB] FAIL lw_req: got %b %b %h %h expected 1 0 2 f", mem_req, mem_we, mem_addr, mem_mask); end
        serve_mem(32'd5, 1);
        checks++; if (retired !== 32'd3) begin errors++; $display("[TB] FAIL lw_retired: got %0d expected 3", retired); end

        serve_fetch(32'h0020_2623, 0);
        step();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 30'h3, 32'd5}) begin errors++; $display("[TB] FAIL sw_x2: got %b %h %h expected 1 3 5", mem_we, mem_addr, mem_wdata); end
        serve_mem(32'd0, 0);

        serve_fetch(32'h0010_06A3, 0);
        step();
        checks++; if ({mem_addr, mem_mask, mem_wdata} !== {30'h3, 4'b0010, 32'h0505_0505}) begin errors++; $display("[TB] FAIL sb_lane: got %h %b %h expected 3 0010 05050505", mem_addr, mem_mask, mem_wdata); end
        serve_mem(32'd0, 0);

        serve_fetch(32'h00D0_0183, 0);
        step();
        serve_mem(32'h0000_8000, 0);
        serve_fetch(32'h0030_2023, 0);
        step();
        checks++; if ({mem_addr, mem_mask, mem_wdata} !== {30'h0, 4'hF, 32'hFFFF_FF80}) begin errors++; $display("[TB] FAIL lb_sext: got %h %h %h expected 0 f ffffff80", mem_addr, mem_mask, mem_wdata); end
        serve_mem(32'd0, 0);
        checks++; if ({retired, instr_addr} !== {32'd7, 30'h47}) begin errors++; $display("[TB] FAIL ls_done: got ret=%0d addr=%h expected 7/47", retired, instr_addr); end
    endtask

    task automatic test_branch();
        serve_fetch(32'h0100_0067, 0);
        step();
        checks++; if (instr_addr !== 30'h4) begin errors++; $display("[TB] FAIL jalr_target: got %h expected 4", instr_addr); end
        serve_fetch(32'hFE00_0CE3, 0);
        step();
        checks++; if (instr_addr !== 30'h2) begin errors++; $display("[TB] FAIL beq_target: got %h expected 2", instr_addr); end
        serve_fetch(32'h0070_0013, 0);
        step();
        serve_fetch(32'h0000_2023, 0);
        step();
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL x0_zero: got %h expected 0", mem_wdata); end
        serve_mem(32'd0, 0);
        checks++; if ({retired, instr_addr} !== {32'd11, 30'h4}) begin errors++; $display("[TB] FAIL br_done: got ret=%0d addr=%h expected 11/4", retired, instr_addr); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int n = 0;
        serve_fetch(32'h0000_2023, 0);
        step();
        while (!halted && n < 12) begin
            if (mem_req) req_cycles++;
            step();
            n++;
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL to_halted: got %b expected 1", halted); end
        checks++; if (req_cycles !== 4) begin errors++; $display("[TB] FAIL to_req_cycles: got %0d expected 4", req_cycles); end
        checks++; if ({mem_req, instr_req} !== 2'b00) begin errors++; $display("[TB] FAIL to_req_dropped: got %b expected 00", {mem_req, instr_req}); end
        mem_ack = 1'b1; instr_ack = 1'b1;
        step(); step();
        mem_ack = 1'b0; instr_ack = 1'b0;
        checks++; if ({halted, retired, instr_addr} !== {1'b1, 32'd11, 30'h4}) begin errors++; $display("[TB] FAIL to_frozen: got %b %0d %h expected 1 11 4", halted, retired, instr_addr); end
        rst = 1'b1;
        #1;
        checks++; if ({halted, instr_req} !== 2'b00) begin errors++; $display("[TB] FAIL to_rst_clear: got %b expected 00", {halted, instr_req}); end
        step();
        rst = 1'b0;
        #1;
        checks++; if ({instr_req, instr_addr, retired} !== {1'b1, 30'h40, 32'd0}) begin errors++; $display("[TB] FAIL to_restart: got %b %h %0d expected 1 40 0", instr_req, instr_addr, retired); end
    endtask

    task automatic test_reset_mid_mem();
        serve_fetch(32'h0000_2023, 0);
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mm_req_up: got %b expected 1", mem_req); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL mm_req_drop: got %b expected 00", {mem_req, mem_we}); end
        step();
        rst = 1'b0; mem_ack = 1'b1;
        step(); step();
        mem_ack = 1'b0;
        checks++; if ({mem_req, instr_req, instr_addr, retired} !== {1'b0, 1'b1, 30'h40, 32'd0}) begin errors++; $display("[TB] FAIL mm_stale_ack: got %b %b %h %0d expected 0 1 40 0", mem_req, instr_req, instr_addr, retired); end
        serve_fetch(32'h0050_0093, 0);
        step();
        checks++; if ({retired, instr_addr} !== {32'd1, 30'h41}) begin errors++; $display("[TB] FAIL mm_resume: got %0d %h expected 1 41", retired, instr_addr); end
    endtask

    initial begin
        rst = 1'b1; instr_ack = 1'b0; mem_ack = 1'b0; instr_data = 32'd0; mem_rdata = 32'd0;
        test_reset();
        test_wait_states();
        test_load_store();
        test_branch();
        test_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
